// File: rtl/msk_mixcolumns_serial_pkg.sv
// Shared definitions for the column-serial masked MixColumns stage:
// FSM encoding, geometry constants and the share-layout byte offset.
package msk_mixcolumns_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int BYTE_W = 8;
  localparam int NCOL   = 4;
  localparam int NROW   = 4;

  // Byte b = 4*c + r of an nsh-share state starts at this bit offset.
  function automatic int byte_off(input int b, input int nsh);
    return BYTE_W * nsh * b;
  endfunction

endpackage

// File: rtl/MSKprodMC.sv
// Sharewise GF(2^8) multiply-by-2 and multiply-by-3 of one masked byte.
// Each share is processed on its own; shares never mix.
module MSKprodMC #(
  parameter int d = 2
) (
  input  logic [8*d-1:0] a,
  output logic [8*d-1:0] x2,
  output logic [8*d-1:0] x3
);

  for (genvar j = 0; j < d; j++) begin : g_share
    logic [7:0] sh;
    logic [7:0] xt;

    for (genvar i = 0; i < 8; i++) begin : g_gather
      assign sh[i] = a[i*d + j];
    end

    // xtime with the AES reduction polynomial; linear, so valid per share.
    assign xt = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);

    for (genvar i = 0; i < 8; i++) begin : g_scatter
      assign x2[i*d + j] = xt[i];
      assign x3[i*d + j] = xt[i] ^ sh[i];
    end
  end

endmodule

// File: rtl/msk_mixcolumn_col.sv
// Combinational MixColumns of one masked column (four bytes, d shares each),
// built from four sharewise x2/x3 units and sharewise XORs.
(* keep_hierarchy = "yes" *)
module msk_mixcolumn_col
  import msk_mixcolumns_serial_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [NROW*BYTE_W*d-1:0] col_in,
  output logic [NROW*BYTE_W*d-1:0] col_out
);

  logic [NROW-1:0][BYTE_W*d-1:0] a;
  logic [NROW-1:0][BYTE_W*d-1:0] x2;
  logic [NROW-1:0][BYTE_W*d-1:0] x3;

  for (genvar r = 0; r < NROW; r++) begin : g_row
    assign a[r] = col_in[byte_off(r, d) +: BYTE_W*d];

    MSKprodMC #(.d(d)) u_prod (
      .a  (a[r]),
      .x2 (x2[r]),
      .x3 (x3[r])
    );

    // out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), identical layout in every share
    assign col_out[byte_off(r, d) +: BYTE_W*d] =
      x2[r] ^ x3[(r+1)%NROW] ^ a[(r+2)%NROW] ^ a[(r+3)%NROW];
  end

endmodule

// File: rtl/msk_mixcolumns_serial.sv
// Masked AES MixColumns stage: loads a d-share state, rewrites one column per
// cycle in place, then presents the register until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on state/reset and out_valid only on state, never
// on in_valid. Once out_valid is high it stays high with sh_state_out stable
// until out_ready is seen.
module msk_mixcolumns_serial
  import msk_mixcolumns_serial_pkg::*;
#(
  parameter int d = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [128*d-1:0]   sh_state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [128*d-1:0]   sh_state_out,
  output logic [1:0]         fsm_state
);

  localparam int COL_W = NROW * BYTE_W * d;

  logic [1:0]         state;
  logic [1:0]         col;
  logic [128*d-1:0]   sh_state;
  logic [COL_W-1:0]   col_in;
  logic [COL_W-1:0]   col_out;

  assign col_in = sh_state[byte_off(NROW*int'(col), d) +: COL_W];

  msk_mixcolumn_col #(.d(d)) u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= 2'd0;
      sh_state <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sh_state <= sh_state_in;
            col      <= 2'd0;
            // The last round skips MixColumns entirely.
            state    <= in_last ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          sh_state[byte_off(NROW*int'(col), d) +: COL_W] <= col_out;
          col <= col + 2'd1;
          if (col == 2'(NCOL-1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ST_IDLE) && rst_n;
  assign out_valid    = (state == ST_DONE);
  assign sh_state_out = sh_state;
  assign fsm_state    = state;

endmodule

// File: tb/tb_msk_mixcolumns_serial.sv
// Bench for msk_mixcolumns_serial: one d=2 and one d=3 instance, a reference
// MixColumns model applied per share, and a per-instance expected queue.
module tb_msk_mixcolumns_serial;

  localparam int W = 384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         iv[2];
  logic         il[2];
  logic         orr[2];
  logic [W-1:0] sin[2];
  logic         ir[2];
  logic         ov[2];
  logic [W-1:0] sout[2];
  logic [1:0]   st[2];

  logic         ir_0, ir_1, ov_0, ov_1;
  logic [255:0] sout_0;
  logic [383:0] sout_1;
  logic [1:0]   st_0, st_1;

  assign ir[0] = ir_0;  assign ir[1] = ir_1;
  assign ov[0] = ov_0;  assign ov[1] = ov_1;
  assign sout[0] = {128'b0, sout_0};
  assign sout[1] = sout_1;
  assign st[0] = st_0;  assign st[1] = st_1;

  msk_mixcolumns_serial #(.d(2)) dut_d2 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv[0]), .in_ready (ir_0), .in_last (il[0]),
    .sh_state_in (sin[0][255:0]),
    .out_valid (ov_0), .out_ready (orr[0]),
    .sh_state_out (sout_0), .fsm_state (st_0)
  );

  msk_mixcolumns_serial #(.d(3)) dut_d3 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv[1]), .in_ready (ir_1), .in_last (il[1]),
    .sh_state_in (sin[1]),
    .out_valid (ov_1), .out_ready (orr[1]),
    .sh_state_out (sout_1), .fsm_state (st_1)
  );

  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q3[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out[2] = '{0, 0};
  int last_acc[2] = '{0, 0};

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mc_plain(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a[4];
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[8*(4*c+r) +: 8];
      for (int r = 0; r < 4; r++)
        y[8*(4*c+r) +: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return y;
  endfunction

  // Column words are written row 0 first (most significant byte).
  function automatic logic [127:0] cols(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] w[4];
    logic [127:0] s;
    w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[8*(4*c+r) +: 8] = w[c][8*(3-r) +: 8];
    return s;
  endfunction

  function automatic logic [127:0] get_share(input logic [W-1:0] s, input int nd, input int j);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++)
      for (int i = 0; i < 8; i++) r[8*b+i] = s[8*nd*b + i*nd + j];
    return r;
  endfunction

  function automatic logic [W-1:0] put_share(input logic [W-1:0] acc, input logic [127:0] sh,
                                             input int nd, input int j);
    logic [W-1:0] r;
    r = acc;
    for (int b = 0; b < 16; b++)
      for (int i = 0; i < 8; i++) r[8*nd*b + i*nd + j] = sh[8*b+i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] make_sharing(input logic [127:0] plain, input int nd);
    logic [W-1:0] s;
    logic [127:0] acc, m;
    s = '0;
    acc = plain;
    for (int j = 0; j < nd-1; j++) begin
      m = rand128();
      acc ^= m;
      s = put_share(s, m, nd, j);
    end
    return put_share(s, acc, nd, nd-1);
  endfunction

  function automatic logic [127:0] recombine(input logic [W-1:0] s, input int nd);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < nd; j++) r ^= get_share(s, nd, j);
    return r;
  endfunction

  function automatic logic [W-1:0] mc_shared(input logic [W-1:0] s, input int nd);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < nd; j++) r = put_share(r, mc_plain(get_share(s, nd, j)), nd, j);
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Presents s and leaves in_valid high; returns on the negedge after acceptance.
  task automatic send(input int k, input logic [W-1:0] s, input logic last);
    int n;
    logic [W-1:0] e;
    n = 0;
    sin[k] = s; il[k] = last; iv[k] = 1'b1;
    while (!ir[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ir[k]) begin
      check_eq("accept_timeout", W'(ir[k]), W'(1));
      iv[k] = 1'b0;
      return;
    end
    e = last ? s : mc_shared(s, k + 2);
    if (k == 0) exp_q2.push_back(e); else exp_q3.push_back(e);
    last_acc[k] = cyc;
    @(negedge clk);
  endtask

  task automatic wait_out(input int k, input int max_cyc);
    int n;
    n = 0;
    while (!ov[k] && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("out_timeout", W'(ov[k]), W'(1));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (ov[k] && orr[k]) begin
          if ((k == 0 ? exp_q2.size() : exp_q3.size()) == 0) begin
            check_eq("sb_unexpected", W'(ov[k]), W'(0));
          end else begin
            e = (k == 0) ? exp_q2.pop_front() : exp_q3.pop_front();
            check_eq(k == 0 ? "sb_d2" : "sb_d3", sout[k], e);
            n_out[k]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] s, e;
    logic [127:0] plain;
    int prev, outs0;

    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; orr[k] = 1'b0; sin[k] = '0;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_in_ready", W'(ir[k]), W'(0));
      check_eq("rst_out_valid", W'(ov[k]), W'(0));
      check_eq("rst_state_reg", sout[k], '0);
      check_eq("rst_fsm", W'(st[k]), W'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", W'(ir[0] & ir[1]), W'(1));

    // FIPS-197 columns, d = 2, with latency checked edge by edge
    plain = cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    s = make_sharing(plain, 2);
    send(0, s, 1'b0);
    iv[0] = 1'b0;
    check_eq("lat_e0", W'(ov[0]), W'(0));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq("lat_busy", W'(ov[0]), W'(0));
    end
    @(negedge clk);
    check_eq("lat_e4", W'(ov[0]), W'(1));
    check_eq("fips_d2_recomb", W'(recombine(sout[0], 2)),
             W'(cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6)));
    orr[0] = 1'b1;
    @(negedge clk);
    check_eq("idle_after_out", W'(ir[0]), W'(1));
    orr[0] = 1'b0;

    // d = 3 columns, random columns 2 and 3
    plain = cols(32'hd4d4d4d5, 32'h2d26314c, $urandom, $urandom);
    s = make_sharing(plain, 3);
    orr[1] = 1'b1;
    send(1, s, 1'b0);
    iv[1] = 1'b0;
    wait_out(1, 10);
    check_eq("d3_recomb_c01", W'(recombine(sout[1], 3) & {64'b0, {64{1'b1}}}),
             W'(cols(32'hd5d5d7d6, 32'h4d7ebdf8, 32'h0, 32'h0)));
    @(negedge clk);

    // Random states, both widths, random last flag
    for (int i = 0; i < 6; i++) begin
      int k;
      k = i % 2;
      orr[k] = 1'b1;
      send(k, make_sharing(rand128(), k + 2), 1'($urandom_range(0, 1)));
      iv[k] = 1'b0;
      wait_out(k, 10);
      @(negedge clk);
    end

    // Last-round bypass
    for (int k = 0; k < 2; k++) begin
      s = make_sharing(rand128(), k + 2);
      orr[k] = 1'b1;
      send(k, s, 1'b1);
      iv[k] = 1'b0;
      check_eq("last_valid_e0", W'(ov[k]), W'(1));
      check_eq("last_bypass", sout[k], s);
      @(negedge clk);
    end

    // Back-pressure: hold 20 cycles in DONE while inputs wiggle
    orr[0] = 1'b0;
    s = make_sharing(rand128(), 2);
    e = mc_shared(s, 2);
    send(0, s, 1'b0);
    wait_out(0, 10);
    for (int i = 0; i < 20; i++) begin
      check_eq("hold_valid", W'(ov[0]), W'(1));
      check_eq("hold_data", sout[0], e);
      check_eq("hold_in_ready", W'(ir[0]), W'(0));
      sin[0] = {128'b0, rand128(), rand128()};
      @(negedge clk);
    end
    orr[0] = 1'b1;
    iv[0] = 1'b0;
    @(negedge clk);
    check_eq("release_in_ready", W'(ir[0]), W'(1));
    check_eq("release_out_valid", W'(ov[0]), W'(0));
    orr[0] = 1'b0;

    // Reset pulse while column 2 is about to be processed
    orr[1] = 1'b0;
    send(1, make_sharing(rand128(), 3), 1'b0);
    repeat (2) @(negedge clk);
    iv[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rstmid_out_valid", W'(ov[k]), W'(0));
      check_eq("rstmid_in_ready", W'(ir[k]), W'(0));
      check_eq("rstmid_fsm", W'(st[k]), W'(0));
    end
    check_eq("rstmid_reg", sout[1], '0);
    exp_q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    orr[1] = 1'b1;
    plain = cols(32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c);
    send(1, make_sharing(plain, 3), 1'b0);
    iv[1] = 1'b0;
    check_eq("recover_lat_e0", W'(ov[1]), W'(0));
    repeat (3) @(negedge clk);
    check_eq("recover_lat_e3", W'(ov[1]), W'(0));
    @(negedge clk);
    check_eq("recover_lat_e4", W'(ov[1]), W'(1));
    check_eq("recover_recomb", W'(recombine(sout[1], 3)),
             W'(cols(32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8)));
    @(negedge clk);

    // Back-to-back with in_valid held high
    outs0 = n_out[1];
    prev = 0;
    orr[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, make_sharing(rand128(), 3), 1'b0);
      if (i > 0) check_eq("b2b_spacing", W'(last_acc[1] - prev), W'(6));
      prev = last_acc[1];
    end
    iv[1] = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("b2b_outputs", W'(n_out[1] - outs0), W'(5));

    check_eq("sb_drain_d2", W'(exp_q2.size()), W'(0));
    check_eq("sb_drain_d3", W'(exp_q3.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/msk_mixcolumns_serial.md
Name: msk_mixcolumns_serial

Overview:
Masked AES MixColumns datapath stage. It accepts a full d-share masked 128-bit state through a valid/ready handshake and applies MixColumns column-serially, one column per cycle, in place in a state register. It instantiates four sharewise x2/x3 units (MSKprodMC) on the current column and consumes their outputs. It sits between ShiftRows and AddRoundKey in the round datapath. It is purely sharewise linear, so it uses no randomness.

Parameters:
d, 2, number of shares (d >= 2)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset; sequential elements clear when rst_n is low
in_valid  in  1  input state valid
in_ready  out  1  block can accept a state
in_last  in  1  final AES round: bypass MixColumns, output the state unchanged
sh_state_in  in  128*d  masked state
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sh_state_out  out  128*d  masked result, driven directly from the state register

Behaviour:
- Share layout: byte b = 4*c + r (c = column, r = row) occupies bits [8*d*b +: 8*d]. Within a byte, bit i of share j is at i*d + j.
- Column math, per share, indices mod 4: out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3). The x2 and x3 terms come from the four MSKprodMC instances.
- FSM states IDLE, BUSY, DONE; 2-bit column counter col.
- Reset: state = IDLE, col = 0, state register = 0, in_ready = 0 while rst_n is low, out_valid = 0.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, load sh_state_in, latch in_last, col <= 0.
  - Next state is DONE if in_last = 1, else BUSY.
- BUSY: each edge replaces column col with its MixColumns result; col increments.
  - At col == 3, the edge writes column 3 and goes to DONE; col wraps to 0.
- DONE: hold the register stable. On out_ready, go to IDLE.
- Latency, with acceptance at edge E0:
  - in_last = 0: out_valid rises after E4 (4 column edges).
  - in_last = 1: out_valid rises after E0.
- Throughput: one state per 6 cycles; the output holds indefinitely under out_ready = 0.
- No overlap: a new input is only accepted in IDLE. Outputs are never combinationally dependent on in_valid.
- Inputs are ignored outside IDLE, and sh_state_in may change freely in BUSY/DONE.
- rst_n asserted in any state: immediate return to reset values and the in-progress state is discarded. Deassertion is synchronised externally.
- Only the selected column is read through the x2/x3 units each cycle. Other columns are held without toggling (no recombination of shares, no cross-share logic).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE = 0, BUSY = 1, DONE = 2)
  - constants BYTE_W = 8, NCOL = 4, NROW = 4
  - the byte-offset helper for the share layout
- Sub-module msk_mixcolumn_col: combinational single masked column (32*d in / 32*d out) built from four MSKprodMC plus sharewise XORs, with keep_hierarchy.
- Top: FSM, counter, column mux/demux, state register.

Test Plan:
- Load FIPS-197 column db 13 53 45 (column 0) and f2 0a 22 5c (column 1); columns 2,3 are 01 01 01 01 and c6 c6 c6 c6; random d = 2 shares, in_last = 0 -> out_valid after 5th edge; recombined output columns are 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6.
- Columns d4 d4 d4 d5 and 2d 26 31 4c, d = 3 random shares -> recombined d5 d5 d7 d6 and 4d 7e bd f8; each share individually equals the sharewise MixColumns of its input share.
- in_last = 1 with any state -> out_valid one cycle after acceptance, output bit-identical to the input sharing.
- Hold out_ready = 0 for 20 cycles in DONE -> out_valid stays 1, sh_state_out stable, in_ready stays 0. Then out_ready = 1 -> IDLE next cycle, in_ready = 1.
- Pulse rst_n low mid-BUSY (col = 2) -> out_valid = 0, in_ready = 0 while low, register cleared. After release a fresh state processes correctly with col starting at 0.
- in_valid held high continuously with back-to-back states -> accepted only in IDLE, one every 6 cycles, no state lost or duplicated.
